bellek_hakem: RTL and testbench

BELLEK_HAKEM -- requirements
Module: bellek_hakem

---
 rtl/bellek_hakem.sv | 120 ++++++++++++
 tb/tb_bellek_hakem.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bellek_hakem.sv
// bellek_hakem: two-port single-memory arbiter, BOS -> ERISIM -> YANIT per transaction.
// Build option: define BELLEK_HAKEM_DONGUSEL_EN for round-robin arbitration (default: port 0 wins).
module bellek_hakem #(
  parameter int ADRES_BIT = 32,
  parameter int VERI_BIT  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 istek0,
  input  logic                 istek1,
  input  logic [ADRES_BIT-1:0] adres0,
  input  logic [ADRES_BIT-1:0] adres1,
  input  logic                 yaz0,
  input  logic                 yaz1,
  input  logic [VERI_BIT-1:0]  yaz_veri0,
  input  logic [VERI_BIT-1:0]  yaz_veri1,
  output logic                 hazir0,
  output logic                 hazir1,
  output logic                 hata0,
  output logic                 hata1,
  output logic [VERI_BIT-1:0]  oku_veri,
  output logic [ADRES_BIT-1:0] bel_adres,
  output logic                 bel_yaz,
  output logic [VERI_BIT-1:0]  bel_yaz_veri,
  input  logic [VERI_BIT-1:0]  bel_oku_veri,
  output logic                 sahip
);

  typedef enum logic [1:0] {BOS, ERISIM, YANIT} durum_t;

  durum_t r_durum;

  logic                 w_kazanan;
  logic [ADRES_BIT-1:0] w_adres_sec;
  logic                 w_yaz_sec;
  logic [VERI_BIT-1:0]  w_veri_sec;
  logic                 w_hizasiz;

`ifdef BELLEK_HAKEM_DONGUSEL_EN
  // Port that won the most recent grant; the other one wins a tie.
  logic r_son;

  always_comb begin
    w_kazanan = 1'b0;
    if (istek0 && istek1) w_kazanan = ~r_son;
    else                  w_kazanan = istek1;
  end
`else
  always_comb begin
    w_kazanan = istek1 & ~istek0;
  end
`endif

  always_comb begin
    w_adres_sec = adres0;
    w_yaz_sec   = yaz0;
    w_veri_sec  = yaz_veri0;
    if (w_kazanan) begin
      w_adres_sec = adres1;
      w_yaz_sec   = yaz1;
      w_veri_sec  = yaz_veri1;
    end
  end

  // bel_adres doubles as the latched address of the current transaction.
  assign w_hizasiz = (bel_adres[1:0] != 2'b00);
  assign oku_veri  = bel_oku_veri;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_durum      <= BOS;
      hazir0       <= 1'b0;
      hazir1       <= 1'b0;
      hata0        <= 1'b0;
      hata1        <= 1'b0;
      bel_yaz      <= 1'b0;
      bel_adres    <= '0;
      bel_yaz_veri <= '0;
      sahip        <= 1'b0;
`ifdef BELLEK_HAKEM_DONGUSEL_EN
      r_son        <= 1'b1;
`endif
    end else begin
      hazir0  <= 1'b0;
      hazir1  <= 1'b0;
      hata0   <= 1'b0;
      hata1   <= 1'b0;
      bel_yaz <= 1'b0;
      case (r_durum)
        BOS: begin
          if (istek0 || istek1) begin
            sahip        <= w_kazanan;
            bel_adres    <= w_adres_sec;
            bel_yaz_veri <= w_veri_sec;
            // Misaligned writes never reach the memory.
            bel_yaz      <= w_yaz_sec && (w_adres_sec[1:0] == 2'b00);
`ifdef BELLEK_HAKEM_DONGUSEL_EN
            r_son        <= w_kazanan;
`endif
            r_durum      <= ERISIM;
          end
        end
        ERISIM: begin
          hazir0  <= ~sahip;
          hazir1  <= sahip;
          hata0   <= ~sahip & w_hizasiz;
          hata1   <= sahip & w_hizasiz;
          r_durum <= YANIT;
        end
        YANIT: begin
          r_durum <= BOS;
        end
        default: begin
          r_durum <= BOS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bellek_hakem.sv
// Self-checking bench for bellek_hakem: vector table plus hand-written arbitration and reset sequences.
// Honours BELLEK_HAKEM_DONGUSEL_EN for the expected grant order.
module tb_bellek_hakem;

  logic        clk;
  logic        rst;
  logic        ld;
  logic        istek0, istek1;
  logic [31:0] adres0, adres1;
  logic        yaz0, yaz1;
  logic [31:0] yaz_veri0, yaz_veri1;
  logic        hazir0, hazir1, hata0, hata1;
  logic [31:0] oku_veri;
  logic [31:0] bel_adres;
  logic        bel_yaz;
  logic [31:0] bel_yaz_veri;
  logic [31:0] bel_oku_veri;
  logic        sahip;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          port;
    logic [31:0] adres;
    bit          yaz;
    logic [31:0] veri;
    bit          hata;
    logic [31:0] oku;
    bit          chk;
  } vec_t;

  typedef struct {
    bit          port;
    bit          hata;
    logic [31:0] oku;
    bit          chk;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t tbl[10];

  logic [31:0] mem [0:15];

  bellek_hakem dut (
    .clk          (clk),
    .rst          (rst),
    .istek0       (istek0),
    .istek1       (istek1),
    .adres0       (adres0),
    .adres1       (adres1),
    .yaz0         (yaz0),
    .yaz1         (yaz1),
    .yaz_veri0    (yaz_veri0),
    .yaz_veri1    (yaz_veri1),
    .hazir0       (hazir0),
    .hazir1       (hazir1),
    .hata0        (hata0),
    .hata1        (hata1),
    .oku_veri     (oku_veri),
    .bel_adres    (bel_adres),
    .bel_yaz      (bel_yaz),
    .bel_yaz_veri (bel_yaz_veri),
    .bel_oku_veri (bel_oku_veri),
    .sahip        (sahip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: write on bel_yaz, read data one cycle after the address.
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 16; i++)
        mem[i] <= (i == 4) ? 32'h1234_5678 : (32'hA5A5_0000 + 32'(i));
    end else if (bel_yaz) begin
      mem[bel_adres[5:2]] <= bel_yaz_veri;
    end
    bel_oku_veri <= mem[bel_adres[5:2]];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (hazir0 || hazir1 || hata0 || hata1)) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_response: got hazir=%b%b hata=%b%b expected none",
                 hazir1, hazir0, hata1, hata0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_hazir", {30'd0, hazir1, hazir0}, mon_e.port ? 32'd2 : 32'd1);
        check("resp_hata", {30'd0, hata1, hata0},
              mon_e.hata ? (mon_e.port ? 32'd2 : 32'd1) : 32'd0);
        if (mon_e.chk) check("resp_oku_veri", oku_veri, mon_e.oku);
      end
    end
  end

  task automatic sb_push(input bit port, input bit hata, input logic [31:0] oku, input bit chk);
    sb_t e;
    e.port = port;
    e.hata = hata;
    e.oku  = oku;
    e.chk  = chk;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_bel_yaz", {31'd0, bel_yaz}, 32'd0);
    check("rst_bel_adres", bel_adres, 32'd0);
    check("rst_bel_yaz_veri", bel_yaz_veri, 32'd0);
    check("rst_sahip", {31'd0, sahip}, 32'd0);
    check("rst_hazir", {30'd0, hazir1, hazir0}, 32'd0);
    check("rst_hata", {30'd0, hata1, hata0}, 32'd0);
  endtask

  // Caller is at a negedge with the arbiter idle.
  task automatic apply(input vec_t v);
    if (v.port) begin
      istek1 = 1'b1; adres1 = v.adres; yaz1 = v.yaz; yaz_veri1 = v.veri;
    end else begin
      istek0 = 1'b1; adres0 = v.adres; yaz0 = v.yaz; yaz_veri0 = v.veri;
    end
    sb_push(v.port, v.hata, v.oku, v.chk);
    @(posedge clk);
    #1;
    istek0 = 1'b0;
    istek1 = 1'b0;
    check("erisim_sahip", {31'd0, sahip}, {31'd0, v.port});
    check("erisim_bel_adres", bel_adres, v.adres);
    check("erisim_bel_yaz", {31'd0, bel_yaz},
          {31'd0, (v.yaz && (v.adres[1:0] == 2'b00))});
    if (v.yaz) check("erisim_bel_yaz_veri", bel_yaz_veri, v.veri);
    check("erisim_hazir", {30'd0, hazir1, hazir0}, 32'd0);
    @(posedge clk);
    #1;
    check("yanit_hazir", {30'd0, hazir1, hazir0}, v.port ? 32'd2 : 32'd1);
    check("yanit_bel_yaz", {31'd0, bel_yaz}, 32'd0);
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    int exp_g[5];
    rst = 1'b1; ld = 1'b1;
    istek0 = 1'b0; istek1 = 1'b0;
    adres0 = '0; adres1 = '0; yaz0 = 1'b0; yaz1 = 1'b0;
    yaz_veri0 = '0; yaz_veri1 = '0;

    tbl[0] = '{1'b1, 32'h8000_0004, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h8000_0004, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};
    tbl[2] = '{1'b0, 32'h8000_0002, 1'b1, 32'h1111_1111, 1'b1, 32'h0, 1'b0};
    tbl[3] = '{1'b0, 32'h8000_0000, 1'b0, 32'h0,         1'b0, 32'hA5A5_0000, 1'b1};
    tbl[4] = '{1'b1, 32'h8000_0008, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0};
    tbl[5] = '{1'b1, 32'h8000_0009, 1'b0, 32'h0,         1'b1, 32'h0, 1'b0};
    tbl[6] = '{1'b0, 32'h8000_0008, 1'b0, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b1};
    tbl[7] = '{1'b0, 32'h8000_0010, 1'b0, 32'h0,         1'b0, 32'h1234_5678, 1'b1};
    tbl[8] = '{1'b1, 32'h8000_000F, 1'b1, 32'h9999_9999, 1'b1, 32'h0, 1'b0};
    tbl[9] = '{1'b1, 32'h8000_000C, 1'b0, 32'h0,         1'b0, 32'hA5A5_0003, 1'b1};

    repeat (2) @(negedge clk);
    ld = 1'b0;
    check_reset_vals();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) apply(tbl[i]);

    // Simultaneous requests held high, then port 0 released: port 1 stays pending.
`ifdef BELLEK_HAKEM_DONGUSEL_EN
    exp_g = '{0, 1, 0, 1, 1};
`else
    exp_g = '{0, 0, 0, 0, 1};
`endif
    #2 rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    istek0 = 1'b1; adres0 = 32'h8000_0018; yaz0 = 1'b0;
    istek1 = 1'b1; adres1 = 32'h8000_001C; yaz1 = 1'b0;
    for (int k = 0; k < 5; k++)
      sb_push(exp_g[k][0], 1'b0, exp_g[k][0] ? 32'hA5A5_0007 : 32'hA5A5_0006, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("grant_order", {31'd0, sahip}, 32'(exp_g[k]));
      if (k == 3) istek0 = 1'b0;
      if (k == 4) istek1 = 1'b0;
      if (k < 4) repeat (2) @(posedge clk);
    end
    wait_idle();

    // Reset during the access cycle of a write aborts it.
    istek0 = 1'b1; adres0 = 32'h8000_0014; yaz0 = 1'b1; yaz_veri0 = 32'h55AA_55AA;
    @(posedge clk);
    #1;
    istek0 = 1'b0;
    check("abort_bel_yaz_before", {31'd0, bel_yaz}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_bel_yaz", {31'd0, bel_yaz}, 32'd0);
    check("abort_bel_adres", bel_adres, 32'd0);
    @(posedge clk);
    #1;
    check("abort_hazir", {30'd0, hazir1, hazir0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply('{1'b0, 32'h8000_0014, 1'b0, 32'h0, 1'b0, 32'hA5A5_0005, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
